// File: rtl/line_period_packer.sv
// Packs signed 8-bit samples into 16-lane 128-bit beats with per-line framing.
// Optional per-line |sample| accumulator enabled by LINE_PACKER_ABS_SUM_EN.
module line_period_packer #(
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [7:0]         in_data,
  input  logic               in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [127:0]       out_data,
  output logic [4:0]         out_bytes,
  output logic               out_last,
`ifdef LINE_PACKER_ABS_SUM_EN
  output logic [31:0]        line_abs_sum,
  output logic               line_abs_sum_valid,
`endif
  output logic [CNT_W-1:0]   out_beat_idx
);

  typedef enum logic {
    FILL,
    HOLD
  } state_t;

  state_t             state_q, state_d;
  logic [3:0]         ptr_q, ptr_d;
  logic [127:0]       fill_q, fill_d;
  logic [127:0]       odata_q, odata_d;
  logic [4:0]         obytes_q, obytes_d;
  logic               olast_q, olast_d;
  logic               ovalid_q, ovalid_d;
  logic [CNT_W-1:0]   idx_q, idx_d;

  logic in_fire;
  logic out_fire;

  assign in_ready = !ovalid_q;
  assign in_fire  = in_valid && (state_q == FILL);
  assign out_fire = ovalid_q && out_ready;

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    fill_d   = fill_q;
    odata_d  = odata_q;
    obytes_d = obytes_q;
    olast_d  = olast_q;
    ovalid_d = ovalid_q;
    idx_d    = idx_q;
    unique case (state_q)
      FILL: begin
        if (in_valid) begin
          fill_d[{ptr_q, 3'b000} +: 8] = in_data;
          ptr_d = ptr_q + 4'd1;
          if (ptr_q == 4'd15 || in_last) begin
            // Beat leaves with the new lane; fill starts clean.
            state_d  = HOLD;
            ovalid_d = 1'b1;
            odata_d  = fill_d;
            obytes_d = {1'b0, ptr_q} + 5'd1;
            olast_d  = in_last;
            ptr_d    = 4'd0;
            fill_d   = '0;
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d  = FILL;
          ovalid_d = 1'b0;
          if (olast_q) begin
            idx_d = '0;
          end else if (idx_q != {CNT_W{1'b1}}) begin
            idx_d = idx_q + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= FILL;
      ptr_q    <= 4'd0;
      fill_q   <= '0;
      odata_q  <= '0;
      obytes_q <= 5'd0;
      olast_q  <= 1'b0;
      ovalid_q <= 1'b0;
      idx_q    <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      fill_q   <= fill_d;
      odata_q  <= odata_d;
      obytes_q <= obytes_d;
      olast_q  <= olast_d;
      ovalid_q <= ovalid_d;
      idx_q    <= idx_d;
    end
  end

  assign out_valid    = ovalid_q;
  assign out_data     = odata_q;
  assign out_bytes    = obytes_q;
  assign out_last     = olast_q;
  assign out_beat_idx = idx_q;

`ifdef LINE_PACKER_ABS_SUM_EN
  logic [8:0]  mag;
  logic [31:0] acc_q, acc_d;
  logic [31:0] sum_q, sum_d;
  logic        sumv_q, sumv_d;

  // 9-bit magnitude so that -128 maps to 128.
  always_comb begin
    mag = in_data[7] ? (9'd0 - {1'b1, in_data}) : {1'b0, in_data};
  end

  always_comb begin
    acc_d  = acc_q;
    sum_d  = sum_q;
    sumv_d = 1'b0;
    if (in_fire) begin
      acc_d = acc_q + {23'd0, mag};
    end
    if (out_fire && olast_q) begin
      sum_d  = acc_q;
      sumv_d = 1'b1;
      acc_d  = 32'd0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q  <= 32'd0;
      sum_q  <= 32'd0;
      sumv_q <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      sum_q  <= sum_d;
      sumv_q <= sumv_d;
    end
  end

  assign line_abs_sum       = sum_q;
  assign line_abs_sum_valid = sumv_q;
`else
  logic unused_fire;
  assign unused_fire = in_fire ^ out_fire;
`endif

endmodule
